// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the decode/EX/MEM/WB pipeline and the hazard controller.
// The pipeline side (master) drives stage info; the controller (slave) drives enables and selects.
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        br_taken;
  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_bubble;
  logic        ifid_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, br_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush,
           fwd_a, fwd_b, state_o, stall_cnt_o
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, br_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush,
           fwd_a, fwd_b, state_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall / branch flush sequencer with EX operand forwarding selects.
// IDLE responses are combinational; LDSTALL/FLUSH responses decode from registered state.
module hazard_ctrl #(
  parameter int MEM_LAT   = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10
  } state_t;

  localparam logic [3:0] LD_RELOAD = 4'(MEM_LAT - 1);
  localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYC - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_stall_cnt;

  logic        w_ld_haz;
  logic        w_stall;
  logic        w_flush;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] m_rd, input logic m_we,
    input logic [4:0] w_rd, input logic w_we
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      return 2'b10;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_ld_haz = bus.id_valid & bus.ex_mem_read & bus.ex_reg_write &
                    (bus.ex_rd != 5'd0) &
                    ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  assign w_fwd_a = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);
  assign w_fwd_b = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);

  // Branch wins over everything; rst_n gates the outputs so reset forces them low immediately.
  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    if (rst_n) begin
      if (bus.br_taken) begin
        w_flush = 1'b1;
      end else begin
        case (r_state)
          LDSTALL: w_stall = 1'b1;
          FLUSH:   w_flush = 1'b1;
          default: w_stall = w_ld_haz;
        endcase
      end
    end
  end

  assign bus.pc_stall    = w_stall;
  assign bus.ifid_stall  = w_stall;
  assign bus.idex_bubble = w_stall | w_flush;
  assign bus.ifid_flush  = w_flush;
  assign bus.fwd_a       = rst_n ? w_fwd_a : 2'b00;
  assign bus.fwd_b       = rst_n ? w_fwd_b : 2'b00;
  assign bus.state_o     = r_state;
  assign bus.stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;

      if (bus.br_taken) begin
        r_state <= (FLUSH_CYC > 1) ? FLUSH : IDLE;
        r_cnt   <= (FLUSH_CYC > 1) ? FL_RELOAD : 4'd0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ld_haz && (MEM_LAT > 1)) begin
              r_state <= LDSTALL;
              r_cnt   <= LD_RELOAD;
            end
          end
          LDSTALL, FLUSH: begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1)
              r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expectations from a cycle-count model,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;
  localparam int MEM_LAT   = 3;
  localparam int FLUSH_CYC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if bus();

  hazard_ctrl #(.MEM_LAT(MEM_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rn;
    logic       vld;
    logic [4:0] r1, r2;
    logic       u1, u2;
    logic [4:0] e1, e2, erd;
    logic       erw, emr;
    logic [4:0] mrd;
    logic       mrw;
    logic [4:0] wrd;
    logic       wrw;
    logic       br;
  } in_t;

  typedef struct {
    logic        pc, ifs, bub, fl;
    logic [1:0]  fa, fb, st;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  int stall_left = 0;
  int flush_left = 0;
  int stall_total = 0;

  function automatic logic [1:0] src_of(input logic [4:0] rs, input logic [4:0] mrd,
                                        input logic mw, input logic [4:0] wrd, input logic ww);
    if (rs == 5'd0) return 2'b00;
    if (mw && mrd == rs) return 2'b10;
    if (ww && wrd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic in_t nop();
    in_t v;
    v = '{rn:1'b1, vld:1'b0, r1:5'd0, r2:5'd0, u1:1'b0, u2:1'b0, e1:5'd0, e2:5'd0,
          erd:5'd0, erw:1'b0, emr:1'b0, mrd:5'd0, mrw:1'b0, wrd:5'd0, wrw:1'b0, br:1'b0};
    return v;
  endfunction

  function automatic in_t load_use(input logic [4:0] rd);
    in_t v;
    v = nop();
    v.vld = 1'b1; v.r1 = rd; v.u1 = 1'b1;
    v.erd = rd; v.erw = 1'b1; v.emr = 1'b1;
    return v;
  endfunction

  function automatic in_t rnd(input bit allow_reset);
    in_t v;
    v.rn  = allow_reset ? ($urandom_range(0, 99) != 0) : 1'b1;
    v.vld = ($urandom_range(0, 3) != 0);
    v.r1  = 5'($urandom_range(0, 3)); v.r2 = 5'($urandom_range(0, 3));
    v.u1  = 1'($urandom); v.u2 = 1'($urandom);
    v.e1  = 5'($urandom_range(0, 3)); v.e2 = 5'($urandom_range(0, 3));
    v.erd = 5'($urandom_range(0, 3));
    v.erw = 1'($urandom); v.emr = 1'($urandom);
    v.mrd = 5'($urandom_range(0, 3)); v.mrw = 1'($urandom);
    v.wrd = 5'($urandom_range(0, 3)); v.wrw = 1'($urandom);
    v.br  = ($urandom_range(0, 9) == 0);
    return v;
  endfunction

  // Apply one cycle of inputs just after the rising edge and push the expected response.
  task automatic cycle(input in_t v);
    exp_t e;
    bit   haz;
    @(posedge clk);
    #1;
    rst_n             = v.rn;
    bus.id_valid      = v.vld;
    bus.id_rs1        = v.r1;
    bus.id_rs2        = v.r2;
    bus.id_use_rs1    = v.u1;
    bus.id_use_rs2    = v.u2;
    bus.ex_rs1        = v.e1;
    bus.ex_rs2        = v.e2;
    bus.ex_rd         = v.erd;
    bus.ex_reg_write  = v.erw;
    bus.ex_mem_read   = v.emr;
    bus.mem_rd        = v.mrd;
    bus.mem_reg_write = v.mrw;
    bus.wb_rd         = v.wrd;
    bus.wb_reg_write  = v.wrw;
    bus.br_taken      = v.br;

    e = '{pc:1'b0, ifs:1'b0, bub:1'b0, fl:1'b0, fa:2'b00, fb:2'b00, st:2'b00, sc:16'd0};
    if (!v.rn) begin
      stall_left  = 0;
      flush_left  = 0;
      stall_total = 0;
    end else begin
      e.sc = 16'(stall_total);
      e.st = (stall_left > 0) ? 2'b01 : (flush_left > 0) ? 2'b10 : 2'b00;
      e.fa = src_of(v.e1, v.mrd, v.mrw, v.wrd, v.wrw);
      e.fb = src_of(v.e2, v.mrd, v.mrw, v.wrd, v.wrw);
      haz  = v.vld && v.emr && v.erw && (v.erd != 0) &&
             ((v.u1 && v.r1 == v.erd) || (v.u2 && v.r2 == v.erd));
      if (v.br) begin
        e.fl = 1'b1; e.bub = 1'b1;
        stall_left = 0;
        flush_left = FLUSH_CYC - 1;
      end else if (stall_left > 0) begin
        e.pc = 1'b1; e.ifs = 1'b1; e.bub = 1'b1;
        stall_left--;
      end else if (flush_left > 0) begin
        e.fl = 1'b1; e.bub = 1'b1;
        flush_left--;
      end else if (haz) begin
        e.pc = 1'b1; e.ifs = 1'b1; e.bub = 1'b1;
        stall_left = MEM_LAT - 1;
      end
      if (e.pc && stall_total < 65535) stall_total++;
    end
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pc_stall",    16'(bus.pc_stall),    16'(e.pc));
      check("ifid_stall",  16'(bus.ifid_stall),  16'(e.ifs));
      check("idex_bubble", 16'(bus.idex_bubble), 16'(e.bub));
      check("ifid_flush",  16'(bus.ifid_flush),  16'(e.fl));
      check("fwd_a",       16'(bus.fwd_a),       16'(e.fa));
      check("fwd_b",       16'(bus.fwd_b),       16'(e.fb));
      check("state_o",     16'(bus.state_o),     16'(e.st));
      check("stall_cnt_o", bus.stall_cnt_o,      e.sc);
    end
  end

  initial begin
    in_t v;
    int  guard;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rd = 0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
    bus.mem_rd = 0; bus.mem_reg_write = 0; bus.wb_rd = 0; bus.wb_reg_write = 0; bus.br_taken = 0;

    // Reset with live hazard/forward inputs: everything must read zero.
    repeat (3) begin
      v = load_use(5'd5); v.rn = 1'b0; v.br = 1'b1;
      v.e1 = 5'd5; v.mrd = 5'd5; v.mrw = 1'b1;
      cycle(v);
    end

    // Load-use: EX load to x5 held for the stall, then it moves on.
    repeat (3) cycle(load_use(5'd5));
    repeat (2) cycle(nop());

    // x0 load and unused rs2 must not stall.
    cycle(load_use(5'd0));
    v = load_use(5'd7); v.r1 = 5'd3; v.r2 = 5'd7; v.u2 = 1'b0;
    cycle(v);

    // Forwarding priority and x0.
    v = nop(); v.e1 = 5'd9; v.mrd = 5'd9; v.wrd = 5'd9; v.mrw = 1'b1; v.wrw = 1'b1;
    cycle(v);
    v.mrw = 1'b0;
    cycle(v);
    v = nop(); v.e2 = 5'd0; v.mrd = 5'd0; v.wrd = 5'd0; v.mrw = 1'b1; v.wrw = 1'b1;
    cycle(v);
    v = nop(); v.e2 = 5'd12; v.wrd = 5'd12; v.wrw = 1'b1; v.mrd = 5'd11; v.mrw = 1'b1;
    cycle(v);

    // Taken branch followed by idle.
    v = nop(); v.br = 1'b1;
    cycle(v);
    repeat (3) cycle(nop());

    // Branch raised during the load stall.
    cycle(load_use(5'd4));
    v = load_use(5'd4); v.br = 1'b1;
    cycle(v);
    repeat (3) cycle(nop());

    // Branch during flush restarts the flush; hazard ignored during flush.
    v = nop(); v.br = 1'b1;
    cycle(v);
    cycle(v);
    cycle(load_use(5'd6));
    cycle(load_use(5'd6));
    repeat (3) cycle(nop());

    // Randomized traffic with occasional resets.
    repeat (2000) cycle(rnd(1'b1));

    // Reset asserted mid-flush, then released: no residual flush.
    v = nop(); v.br = 1'b1;
    cycle(v);
    v = load_use(5'd3); v.br = 1'b1; v.rn = 1'b0;
    cycle(v);
    repeat (3) cycle(nop());

    // Saturation: continuous hazard longer than the counter range.
    v = nop(); v.rn = 1'b0;
    cycle(v);
    repeat (65540) cycle(load_use(5'd8));
    repeat (2) cycle(nop());

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
